// File: rtl/prio_arb_pkg.sv
// Shared constants, FSM state encoding and the index-to-one-hot helper
// for the eight-requester priority arbiter.
package prio_arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
        return oh;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational winner picker: rotates the request vector so the pointer slot
// is on top, takes the highest set bit, then maps it back to a requester index.
module rr_prio_pick
    import prio_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             mode,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_vld
);

    logic [IDX_W-1:0] top_s;
    logic [N_REQ-1:0] rot_s;
    logic [IDX_W-1:0] enc_s;

    // Fixed priority is round-robin with the pointer pinned at the top index.
    always_comb begin
        top_s = mode ? ptr : IDX_W'(N_REQ - 1);
        rot_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rot_s[i] = req[IDX_W'(i + int'(top_s) + 1)];
        end
        enc_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            enc_s = rot_s[i] ? IDX_W'(i) : enc_s;
        end
        win_idx = enc_s + top_s + IDX_W'(1);
        win_vld = |req;
    end

endmodule

// File: rtl/prio_arb_8.sv
// Eight-requester arbiter, fixed or round-robin priority, with grant hold,
// release, dropped-request exit and optional hold-limit revoke.
module prio_arb_8
    import prio_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             mode,
    input  logic             rel,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             timeout
);

    localparam logic             HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : '0;

    arb_state_e       state_r;
    logic [CNT_W-1:0] hold_cnt_r;
    logic [IDX_W-1:0] rr_ptr_r;
    logic [IDX_W-1:0] win_idx_s;
    logic             win_vld_s;
    logic             drop_s;
    logic             limit_s;
    logic             exit_s;

    rr_prio_pick u_pick (
        .req     (req),
        .ptr     (rr_ptr_r),
        .mode    (mode),
        .win_idx (win_idx_s),
        .win_vld (win_vld_s)
    );

    // Grant exit causes; release and dropped request outrank the hold limit.
    always_comb begin
        drop_s  = ~req[gnt_idx];
        limit_s = HOLD_EN && (hold_cnt_r == HOLD_LAST);
        exit_s  = rel | drop_s | limit_s;
    end

    // Arbitration FSM with registered grant outputs and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            hold_cnt_r <= '0;
            rr_ptr_r   <= IDX_W'(N_REQ - 1);
            gnt        <= '0;
            gnt_idx    <= '0;
            gnt_vld    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    timeout    <= 1'b0;
                    hold_cnt_r <= '0;
                    if (win_vld_s) begin
                        gnt      <= idx_to_onehot(win_idx_s);
                        gnt_idx  <= win_idx_s;
                        gnt_vld  <= 1'b1;
                        rr_ptr_r <= win_idx_s - IDX_W'(1);
                        state_r  <= GRANT;
                    end else begin
                        gnt     <= '0;
                        gnt_idx <= '0;
                        gnt_vld <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                GRANT: begin
                    if (exit_s) begin
                        gnt        <= '0;
                        gnt_idx    <= '0;
                        gnt_vld    <= 1'b0;
                        timeout    <= ~(rel | drop_s);
                        hold_cnt_r <= '0;
                        state_r    <= IDLE;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + CNT_W'(1);
                        timeout    <= 1'b0;
                        state_r    <= GRANT;
                    end
                end
                default: begin
                    gnt        <= '0;
                    gnt_idx    <= '0;
                    gnt_vld    <= 1'b0;
                    timeout    <= 1'b0;
                    hold_cnt_r <= '0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prio_arb_8.sv
// Bench for prio_arb_8: directed cycle tables, async-reset sequences and a
// randomized run against an owner/last-winner reference model.
module tb_prio_arb_8;

    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'd0;
    logic       mode = 1'b0;
    logic       rel = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    prio_arb_8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .mode    (mode),
        .rel     (rel),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       mode;
        logic       rel;
        logic [7:0] e_gnt;
        logic [2:0] e_idx;
        logic       e_vld;
        logic       e_to;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [7:0] q, input logic m,
                                input logic l, input logic [7:0] eg, input logic [2:0] ei,
                                input logic ev, input logic et, input int n = 1);
        vec_t v;
        v.rst = r; v.req = q; v.mode = m; v.rel = l;
        v.e_gnt = eg; v.e_idx = ei; v.e_vld = ev; v.e_to = et;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [7:0] eg, input logic [2:0] ei,
                         input logic ev, input logic et, input logic chk_idx);
        n_cmp++;
        if (gnt !== eg || gnt_vld !== ev || timeout !== et ||
            ((ev || chk_idx) && gnt_idx !== ei)) begin
            n_bad++;
            $display("FAIL %s: got gnt=%b idx=%0d vld=%b to=%b, want gnt=%b idx=%0d vld=%b to=%b",
                     name, gnt, gnt_idx, gnt_vld, timeout, eg, ei, ev, et);
        end
        n_cmp++;
        if (gnt_vld !== (gnt != 8'd0) || (gnt_vld && gnt !== (8'd1 << gnt_idx))) begin
            n_bad++;
            $display("FAIL %s invariant: got gnt=%b idx=%0d vld=%b", name, gnt, gnt_idx, gnt_vld);
        end
    endtask

    // Reference model: who owns the resource, for how long, and who won last.
    int owner = -1;
    int len   = 0;
    int last  = 0;
    bit m_to  = 1'b0;

    function automatic int pick(input logic [7:0] r, input logic m);
        if (!m) begin
            for (int i = 7; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int k = 0; k < 8; k++) if (r[(last + 7 - k) % 8]) return (last + 7 - k) % 8;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [7:0] r, input logic m, input logic l);
        if (owner < 0) begin
            m_to = 1'b0;
            if (r != 8'd0) begin
                owner = pick(r, m);
                len   = 1;
                last  = owner;
            end
        end else if (l || !r[owner] || (MAX_HOLD != 0 && len == MAX_HOLD)) begin
            m_to  = !l && r[owner];
            owner = -1;
        end else begin
            len++;
            m_to = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Fixed mode hold and release, re-grant after one dead cycle.
        add(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        add(1'b0, 8'hCC, 1'b0, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0, 3);
        add(1'b0, 8'hCC, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
        add(1'b0, 8'hCC, 1'b0, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0);
        add(1'b0, 8'hCC, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
        // Round-robin alternation 4,1,4,1 from reset.
        add(1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            add(1'b0, 8'h12, 1'b1, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0);
            add(1'b0, 8'h12, 1'b1, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
            add(1'b0, 8'h12, 1'b1, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
            add(1'b0, 8'h12, 1'b1, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
        end
        // Hold limit: 16 grant cycles, timeout pulse, regrant; then limit
        // coinciding with rel and with a dropped request gives no timeout.
        add(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        add(1'b0, 8'h04, 1'b0, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0, 16);
        add(1'b0, 8'h04, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        add(1'b0, 8'h04, 1'b0, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0, 16);
        add(1'b0, 8'h04, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
        add(1'b0, 8'h04, 1'b0, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0, 16);
        add(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 2);
        // No pre-emption by a higher request; it wins the next arbitration.
        add(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        add(1'b0, 8'h02, 1'b0, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
        add(1'b0, 8'h82, 1'b0, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0, 3);
        add(1'b0, 8'h82, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
        add(1'b0, 8'h82, 1'b0, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0);
        // Request drop by owner 3 without rel.
        add(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        add(1'b0, 8'h08, 1'b0, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0, 2);
        add(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 2);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; req = vecs[i].req; mode = vecs[i].mode; rel = vecs[i].rel;
            tick();
            check($sformatf("vec%0d", i), vecs[i].e_gnt, vecs[i].e_idx, vecs[i].e_vld,
                  vecs[i].e_to, vecs[i].rst);
        end

        // Async reset mid-grant, then round-robin pointer must be back at 7.
        rst = 1'b0; req = 8'h08; mode = 1'b0; rel = 1'b0;
        tick();
        check("own3", 8'h08, 3'd3, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 check("async_rst_a", 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
        req = 8'h12; mode = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("rr_after_rst", 8'h10, 3'd4, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 check("async_rst_b", 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
        req = 8'h01; mode = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("grant0_after_rst", 8'h01, 3'd0, 1'b1, 1'b0, 1'b0);

        // Randomized run against the reference model.
        rst = 1'b1; req = 8'h00; rel = 1'b0;
        tick();
        rst = 1'b0;
        owner = -1; len = 0; last = 0; m_to = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 3) == 0) req = 8'h00;
                else req = 8'($urandom) & 8'($urandom);
            end
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            rel = ($urandom_range(0, 9) == 0);
            @(posedge clk);
            model_step(req, mode, rel);
            #1;
            check($sformatf("rand%0d", c),
                  (owner >= 0) ? (8'd1 << owner) : 8'd0,
                  (owner >= 0) ? 3'(owner) : 3'd0,
                  owner >= 0, m_to, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prio_arb_8.md
Name: prio_arb_8

Overview:
- Eight-requester arbiter that shares one resource (bus or datapath slot) among requesters using priority encoding.
- Supports fixed priority (bit 7 highest, same ordering as the team's 8x3 priority encoder) and round-robin priority, selected at run time.
- Holds a grant until the owner releases it, drops its request, or exceeds a hold limit.
- Sits between requester blocks and the shared resource mux; `gnt_idx` drives the mux select directly.

Parameters:
- N_REQ, 8, number of requesters (fixed at 8 in this revision).
- IDX_W, 3, width of the grant index.
- MAX_HOLD, 16, maximum grant length in cycles before forced revoke; 0 disables the timeout.
- CNT_W, 5, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req  input  8  request vector, bit i = requester i; level-sensitive.
- mode  input  1  0 = fixed priority (7 highest), 1 = round-robin; sampled only in IDLE.
- rel  input  1  release strobe from the current owner; ignored in IDLE.
- gnt  output  8  one-hot grant, registered.
- gnt_idx  output  3  binary index of the granted requester, registered.
- gnt_vld  output  1  a grant is active, registered.
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Reset (async, while rst=1):
  - gnt=0, gnt_idx=0, gnt_vld=0, timeout=0.
  - state=IDLE, hold counter=0, rr_ptr=7.
- FSM states: IDLE, GRANT.
- IDLE:
  - If req != 0 at a rising edge: pick the winner, load gnt/gnt_idx, set gnt_vld=1, clear the hold counter, go to GRANT.
  - Grant latency is one edge: req visible before edge N gives gnt valid after edge N.
  - If req == 0: stay in IDLE, outputs stay 0.
- Winner selection, fixed mode: highest set index wins.
- Winner selection, round-robin mode:
  - Search descends from rr_ptr, wrapping 0 -> 7; the first set bit wins.
  - On each grant to index i, rr_ptr <= (i-1) mod 8, so the winner becomes lowest priority next time.
  - rr_ptr is updated in fixed mode as well, so switching modes is seamless.
- GRANT:
  - The hold counter increments each cycle.
  - Exit to IDLE at the edge where any of these holds:
    - rel=1;
    - req[gnt_idx]=0;
    - MAX_HOLD != 0 and the counter reaches MAX_HOLD-1.
  - On exit: gnt=0, gnt_vld=0.
  - timeout=1 for exactly that one cycle, only when the exit cause is the hold limit and neither rel nor a dropped request applies. rel or a dropped request takes precedence, so simultaneous causes give timeout=0.
  - Grant length is therefore at most MAX_HOLD cycles.
- Re-arbitration: there is always one dead IDLE cycle between consecutive grants; no back-to-back handover. The bench checks gnt_vld=0 for one cycle.
- Requests changing during GRANT do not pre-empt the owner, even if higher priority.
- mode changes during GRANT take effect at the next IDLE arbitration.
- rel while IDLE has no effect.
- Reset mid-grant clears all outputs immediately, without waiting for clk; rr_ptr returns to 7.
- Invariants:
  - gnt is one-hot or zero.
  - gnt_vld == (gnt != 0).
  - gnt == (1 << gnt_idx) whenever gnt_vld=1.

Decomposition:
- Shared package prio_arb_pkg holds:
  - N_REQ and IDX_W constants;
  - the state encoding (IDLE=1'b0, GRANT=1'b1);
  - a function for index-to-one-hot conversion.
- One combinational sub-module, rr_prio_pick:
  - inputs: req[7:0], ptr[2:0], mode;
  - outputs: win_idx[2:0], win_vld;
  - implementation: rotate req by ptr, priority-encode, un-rotate.
- The FSM, hold counter and rr_ptr live in prio_arb_8.

Test Plan:
- Fixed mode, req=8'b11001100 held, rel pulsed after 3 grant cycles -> gnt=8'b10000000, gnt_idx=7 for 3 cycles, 1 idle cycle, then gnt_idx=7 again.
- Round-robin, req=8'b00010010 held, rel after each grant -> gnt_idx sequence 4,1,4,1 with gnt_vld gaps of 1 cycle; from reset (rr_ptr=7) the first winner is 4.
- Timeout with MAX_HOLD=16, req=8'b00000100 held, no rel -> gnt_idx=2 for exactly 16 cycles, timeout=1 for 1 cycle, regrant to 2 after the dead cycle.
- Pre-emption check: owner index 1, then raise req[7] -> no change until rel; next arbitration picks 7 in fixed mode.
- Request drop: owner index 3 drops req[3] with rel=0 -> gnt clears next edge, timeout=0.
- Async reset asserted mid-grant between clock edges -> gnt, gnt_idx, gnt_vld and timeout all 0 immediately; req=8'b00000001 after reset release gives gnt_idx=0 one edge later.
